// File: rtl/rev_level_moore.sv
// rtl/rev_level_moore.sv - tachometer-based revolution level Moore FSM (C = state)
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   A            engine on (1) / off (0), synchronous to clk
//   tach_in      raw tachometer pulse, asynchronous to clk
//   C            revolution level 00..11, driven straight from the state register
//   level_valid  high once a full window has completed since A rose
//   pulse_cnt    pulse count of the last completed window
//   window_done  one-cycle strobe when a window completes
module rev_level_moore #(
    parameter int WINDOW_CYC = 1000,
    parameter int CNT_W      = 16,
    parameter int TH1        = 10,
    parameter int TH2        = 30,
    parameter int TH3        = 60,
    parameter int HYST       = 2,
    parameter int CONFIRM    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             A,
    input  logic             tach_in,
    output logic [1:0]       C,
    output logic             level_valid,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic             window_done
);

    localparam int WIN_W  = $clog2(WINDOW_CYC);
    localparam int CONF_W = $clog2(CONFIRM + 1);

    localparam logic [1:0] LVL0 = 2'b00;
    localparam logic [1:0] LVL1 = 2'b01;
    localparam logic [1:0] LVL2 = 2'b10;
    localparam logic [1:0] LVL3 = 2'b11;

    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CONF_W-1:0] CONF_C   = CONF_W'(CONFIRM);

    // Up thresholds (enter level L) and down thresholds (leave level L, with hysteresis)
    localparam logic [CNT_W-1:0] UP1 = CNT_W'(TH1);
    localparam logic [CNT_W-1:0] UP2 = CNT_W'(TH2);
    localparam logic [CNT_W-1:0] UP3 = CNT_W'(TH3);
    localparam logic [CNT_W-1:0] DN1 = CNT_W'(TH1 - HYST);
    localparam logic [CNT_W-1:0] DN2 = CNT_W'(TH2 - HYST);
    localparam logic [CNT_W-1:0] DN3 = CNT_W'(TH3 - HYST);

    logic [1:0]        state_q, state_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [CNT_W-1:0]  run_q, run_d;
    logic [CNT_W-1:0]  pc_q, pc_d;
    logic [CONF_W-1:0] up_q, up_d;
    logic [CONF_W-1:0] dn_q, dn_d;
    logic              lv_q, lv_d;
    logic              wd_q, wd_d;
    logic              sync1_q, sync2_q, sync3_q;

    logic              tach_edge;
    logic              win_last;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  n_final;
    logic [CNT_W-1:0]  th_up, th_dn;
    logic              up_qual, dn_qual;
    logic [CONF_W-1:0] up_inc, dn_inc;

    // Two synchronizer flops plus one more stage for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= tach_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign tach_edge = sync2_q & ~sync3_q;
    assign win_last  = (win_q == WIN_LAST);
    assign cnt_inc   = (run_q == CNT_MAX) ? run_q : run_q + 1'b1;
    // Count including an edge seen this cycle; at the last window cycle this is the final count
    assign n_final   = tach_edge ? cnt_inc : run_q;

    always_comb begin
        th_up = UP1;
        th_dn = '0;
        case (state_q)
            LVL0: begin th_up = UP1; th_dn = '0;  end
            LVL1: begin th_up = UP2; th_dn = DN1; end
            LVL2: begin th_up = UP3; th_dn = DN2; end
            default: begin th_up = '1; th_dn = DN3; end
        endcase
    end

    assign up_qual = (state_q != LVL3) && (n_final >= th_up);
    assign dn_qual = (state_q != LVL0) && (n_final < th_dn);
    assign up_inc  = up_q + 1'b1;
    assign dn_inc  = dn_q + 1'b1;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        run_d   = run_q;
        pc_d    = pc_q;
        up_d    = up_q;
        dn_d    = dn_q;
        lv_d    = lv_q;
        wd_d    = 1'b0;
        if (!A) begin
            // Engine off: park at level 0, drop the window in progress, keep pulse_cnt
            state_d = LVL0;
            win_d   = '0;
            run_d   = '0;
            up_d    = '0;
            dn_d    = '0;
            lv_d    = 1'b0;
        end else if (win_last) begin
            win_d = '0;
            run_d = '0;
            pc_d  = n_final;
            wd_d  = 1'b1;
            lv_d  = 1'b1;
            // Up and down qualification are mutually exclusive since th_dn < th_up
            if (up_qual) begin
                dn_d = '0;
                if (up_inc == CONF_C) begin
                    state_d = state_q + 2'd1;
                    up_d    = '0;
                end else begin
                    up_d = up_inc;
                end
            end else if (dn_qual) begin
                up_d = '0;
                if (dn_inc == CONF_C) begin
                    state_d = state_q - 2'd1;
                    dn_d    = '0;
                end else begin
                    dn_d = dn_inc;
                end
            end else begin
                up_d = '0;
                dn_d = '0;
            end
        end else begin
            win_d = win_q + 1'b1;
            run_d = n_final;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LVL0;
            win_q   <= '0;
            run_q   <= '0;
            pc_q    <= '0;
            up_q    <= '0;
            dn_q    <= '0;
            lv_q    <= 1'b0;
            wd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            run_q   <= run_d;
            pc_q    <= pc_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            lv_q    <= lv_d;
            wd_q    <= wd_d;
        end
    end

    assign C           = state_q;
    assign level_valid = lv_q;
    assign pulse_cnt   = pc_q;
    assign window_done = wd_q;

endmodule

// File: tb/tb_rev_level_moore.sv
// tb/tb_rev_level_moore.sv - directed self-checking bench for rev_level_moore
module tb_rev_level_moore;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        A = 1'b0;
    logic        tach_in = 1'b0;
    logic [1:0]  C;
    logic        level_valid;
    logic [15:0] pulse_cnt;
    logic        window_done;

    int n_assert = 0;
    int n_fail   = 0;

    rev_level_moore #(
        .WINDOW_CYC(20), .CNT_W(16), .TH1(2), .TH2(4), .TH3(6), .HYST(1), .CONFIRM(2)
    ) dut (
        .clk(clk), .reset(reset), .A(A), .tach_in(tach_in),
        .C(C), .level_valid(level_valid), .pulse_cnt(pulse_cnt), .window_done(window_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n 1-high/1-low pulses, highs at window cycles 2,4,..,2n
    function automatic logic [19:0] pmask(input int n);
        logic [19:0] m;
        m = '0;
        for (int i = 1; i <= n; i++) m[2*i] = 1'b1;
        return m;
    endfunction

    // Drives one full 20-cycle window starting in the current cycle (window cycle 0)
    task automatic run_window(input logic [19:0] mask, input int exp_cnt,
                              input logic [1:0] exp_c, input string tag);
        for (int k = 0; k < 20; k++) begin
            tach_in = mask[k];
            tick();
            if (k < 19) check({tag, " early_done"}, {31'd0, window_done}, 32'd0);
        end
        tach_in = 1'b0;
        check({tag, " done"},  {31'd0, window_done}, 32'd1);
        check({tag, " cnt"},   {16'd0, pulse_cnt},   exp_cnt);
        check({tag, " C"},     {30'd0, C},           {30'd0, exp_c});
        check({tag, " valid"}, {31'd0, level_valid}, 32'd1);
    endtask

    initial begin
        // Reset held with tach toggling
        for (int i = 0; i < 6; i++) begin
            tach_in = ~tach_in;
            tick();
            check("rst C",     {30'd0, C},           32'd0);
            check("rst valid", {31'd0, level_valid}, 32'd0);
            check("rst done",  {31'd0, window_done}, 32'd0);
            check("rst cnt",   {16'd0, pulse_cnt},   32'd0);
        end
        reset   = 1'b0;
        tach_in = 1'b0;
        tick(); tick(); tick();
        check("idle C",     {30'd0, C},           32'd0);
        check("idle valid", {31'd0, level_valid}, 32'd0);

        // 5 pulses/window: 00,01,01,10,10
        A = 1'b1;
        run_window(pmask(5), 5, 2'd0, "w5a");
        run_window(pmask(5), 5, 2'd1, "w5b");
        run_window(pmask(5), 5, 2'd1, "w5c");
        run_window(pmask(5), 5, 2'd2, "w5d");
        run_window(pmask(5), 5, 2'd2, "w5e");

        // From LVL2: 3 is not below TH2-HYST, then 2 steps down after confirmation
        run_window(pmask(3), 3, 2'd2, "w3a");
        run_window(pmask(3), 3, 2'd2, "w3b");
        run_window(pmask(3), 3, 2'd2, "w3c");
        run_window(pmask(2), 2, 2'd2, "w2a");
        run_window(pmask(2), 2, 2'd1, "w2b");

        // Confirmation broken by an intervening window
        run_window(pmask(5), 5, 2'd1, "cf5a");
        run_window(pmask(0), 0, 2'd1, "cf0");
        run_window(pmask(5), 5, 2'd1, "cf5b");
        run_window(pmask(5), 5, 2'd2, "cf5c");

        // Up to LVL3
        run_window(pmask(6), 6, 2'd2, "w6a");
        run_window(pmask(6), 6, 2'd3, "w6b");
        run_window(pmask(7), 7, 2'd3, "w7top");

        // A drops for one cycle mid-window
        for (int k = 0; k < 5; k++) tick();
        A = 1'b0;
        tick();
        check("off C",     {30'd0, C},           32'd0);
        check("off valid", {31'd0, level_valid}, 32'd0);
        check("off done",  {31'd0, window_done}, 32'd0);
        check("off cnt",   {16'd0, pulse_cnt},   32'd7);
        A = 1'b1;
        // Fresh window ends 20 cycles later; large count still steps by one
        run_window(pmask(8), 8, 2'd0, "big1");
        run_window(pmask(8), 8, 2'd1, "big2");

        // Edge detected in the last window cycle belongs to that window
        begin
            logic [19:0] m;
            m = '0;
            m[17] = 1'b1;
            run_window(m, 1, 2'd1, "last");
        end
        run_window(pmask(0), 0, 2'd1, "after");

        // A falling in the last cycle discards the window
        for (int k = 0; k < 19; k++) tick();
        A = 1'b0;
        tick();
        check("drop done", {31'd0, window_done}, 32'd0);
        check("drop C",    {30'd0, C},           32'd0);
        check("drop cnt",  {16'd0, pulse_cnt},   32'd0);

        // Asynchronous reset mid-window
        A = 1'b1;
        run_window(pmask(5), 5, 2'd0, "pre_rst_a");
        run_window(pmask(5), 5, 2'd1, "pre_rst_b");
        tick(); tick(); tick();
        #3;
        reset = 1'b1;
        #1;
        check("arst C",     {30'd0, C},           32'd0);
        check("arst valid", {31'd0, level_valid}, 32'd0);
        check("arst cnt",   {16'd0, pulse_cnt},   32'd0);
        check("arst done",  {31'd0, window_done}, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rev_level_moore.md
Name: rev_level_moore

Overview:
- Moore FSM that produces the 2-bit revolution level C consumed by the gear/mode Mealy FSM.
- Measures tachometer pulses over fixed measurement windows and quantizes the count into four levels.
- Hysteresis plus multi-window confirmation suppress level chatter.
- Level steps by at most one per decision. Forced to level 0 while the engine is off (A=0).

Parameters:
- WINDOW_CYC, 1000, clk cycles per measurement window (>=4)
- CNT_W, 16, width of pulse counter; saturates at all-ones
- TH1, 10, min window count for level 1
- TH2, 30, min window count for level 2 (TH2>TH1)
- TH3, 60, min window count for level 3 (TH3>TH2)
- HYST, 2, down-threshold margin (HYST<TH1)
- CONFIRM, 2, consecutive qualifying windows required per step (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- A  in  1  engine on (1) / off (0); synchronous to clk
- tach_in  in  1  raw tachometer pulse, asynchronous
- C  out  2  revolution level (00..11), Moore output = state encoding
- level_valid  out  1  high once at least one full window has completed since A rose
- pulse_cnt  out  CNT_W  pulse count of last completed window
- window_done  out  1  one-cycle strobe when a window completes

Behaviour:
- Reset values: C=00 (state LVL0), level_valid=0, pulse_cnt=0, window_done=0; all internal counters and synchronizer flops 0.
- Input conditioning: tach_in passes through a 2-FF synchronizer, then a rising-edge detector (sync2 & ~sync3). Each detected edge adds 1 to the running count, saturating at 2^CNT_W-1.
- Window timing:
  - Window counter runs 0..WINDOW_CYC-1 while A=1.
  - An edge detected in the last cycle counts toward the current window.
  - On the cycle after the last window cycle: window_done=1, pulse_cnt=final count, running count restarts at 0 (or 1 if an edge is detected that same cycle), and level_valid becomes 1.
- States: LVL0 / LVL1 / LVL2 / LVL3, encoded 00/01/10/11; C is driven directly from the state register.
- Decision: evaluated only at window completion, using n = completed count and current level L.
  - up-qualify: L<3 and n >= TH(L+1)
  - down-qualify: L>0 and n < TH(L) - HYST
  - up_cnt increments on an up-qualifying window, else clears. down_cnt behaves the same for down-qualifying windows. A window cannot qualify both ways.
  - When up_cnt reaches CONFIRM: L <- L+1 and both counters clear. When down_cnt reaches CONFIRM: L <- L-1 and both counters clear.
  - C changes in the same cycle window_done is high.
- Single-step rule: a very large count still moves L by one per confirmed decision.
- A=0 (sampled each cycle), effective from the next edge:
  - state = LVL0; window counter, running count, up_cnt, down_cnt cleared; level_valid=0; window_done=0.
  - pulse_cnt holds its last value.
  - Tach edges are ignored.
- A rising 0->1: a fresh window starts at counter 0 on the first cycle A=1 is sampled.
- A falling in the last window cycle: the window is discarded (no window_done).
- Reset mid-window: all state returns to reset values immediately, asynchronously.
- Saturation: once at all-ones, the running count holds until the window ends.

Test Plan (WINDOW_CYC=20, TH1=2, TH2=4, TH3=6, HYST=1, CONFIRM=2, 1-high/1-low tach pulses):
- Reset held, tach toggling -> C=00, level_valid=0, window_done=0, pulse_cnt=0 throughout.
- A=1, 5 pulses/window for 5 windows:
  - pulse_cnt=5 at each window_done
  - C: 00, 01 (end of window 2), 01, 10 (end of window 4), 10
  - level_valid=1 from the first window_done
- From LVL2:
  - 3 pulses/window for 3 windows -> C stays 10, since 3 is not < TH2-HYST=3.
  - Then 2 pulses/window -> C=01 at the second such window.
- Confirmation reset: at LVL1, window sequence 5, 0, 5 pulses -> no step up (up_cnt cleared by the intervening window); a following 5-pulse window -> C=10.
- A=1 at LVL3, then A=0 for 1 cycle mid-window -> next cycle C=00, level_valid=0. After A returns to 1, window_done occurs 20 cycles later.
- Pulse edge in the last window cycle -> counted in that window's pulse_cnt, not in the next window's.
